// File: rtl/ether_tx_pkg.sv
// Shared types and constants for the RMII Ethernet frame transmitter.
package ether_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_FCS,
        ST_IFG
    } tx_state_e;

    localparam int unsigned PREAMBLE_DIBITS = 28;
    localparam int unsigned HEADER_BYTES    = 14;
    localparam int unsigned FCS_DIBITS      = 16;
    localparam int unsigned IFG_CYCLES      = 48;
    localparam int unsigned BYTE_W          = 11;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

endpackage

// File: rtl/ether_tx_crc32_dibit.sv
// Reflected CRC-32 register advanced two bits per enabled cycle, din[0] first.
module crc32_dibit
    import ether_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [1:0]  din,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] step;

    always_comb begin
        step = crc_q;
        for (int i = 0; i < 2; i++) begin
            step = (step >> 1) ^ (CRC_POLY & {32{step[0] ^ din[i]}});
        end
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ether_tx.sv
// RMII Ethernet II transmitter: preamble, SFD, fixed header, streamed payload, FCS, IFG.
module ether_tx
    import ether_tx_pkg::*;
#(
    parameter logic [47:0] DST_MAC       = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC       = 48'h42_42_42_42_42_42,
    parameter logic [15:0] ETHERTYPE     = 16'h0800,
    parameter int unsigned PAYLOAD_BYTES = 46
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    output logic       axiir,
    output logic       txen,
    output logic [1:0] txd,
    output logic       busy,
    output logic       underrun
);

    localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

    tx_state_e         state_q, state_d, next_st;
    logic [BYTE_W-1:0] byte_q, byte_d, last_byte;
    logic [1:0]        dibit_q, dibit_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        next_byte;
    logic [3:0]        hdr_idx;
    logic [31:0]       crc;
    logic [31:0]       fcs;
    logic              txen_d, busy_d, underrun_d;
    logic [1:0]        txd_d;
    logic              crc_init_c, crc_en_c;

    // Length and successor of every timed state.
    always_comb begin
        last_byte = '0;
        next_st   = ST_IDLE;
        unique case (state_q)
            ST_PREAMBLE: begin last_byte = BYTE_W'(PREAMBLE_DIBITS / 4 - 1); next_st = ST_SFD;     end
            ST_SFD:      begin last_byte = '0;                               next_st = ST_HEADER;  end
            ST_HEADER:   begin last_byte = BYTE_W'(HEADER_BYTES - 1);        next_st = ST_PAYLOAD; end
            ST_PAYLOAD:  begin last_byte = BYTE_W'(PAYLOAD_BYTES - 1);       next_st = ST_FCS;     end
            ST_FCS:      begin last_byte = BYTE_W'(FCS_DIBITS / 4 - 1);      next_st = ST_IFG;     end
            ST_IFG:      begin last_byte = BYTE_W'(IFG_CYCLES / 4 - 1);      next_st = ST_IDLE;    end
            default:     ;
        endcase
    end

    // Position sequencing: the IFG is counted in the same byte/dibit units.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        dibit_d = dibit_q;
        if (state_q == ST_IDLE) begin
            if (axiiv) begin
                state_d = ST_PREAMBLE;
                byte_d  = '0;
                dibit_d = '0;
            end
        end else if (dibit_q == 2'd3 && byte_q == last_byte) begin
            state_d = next_st;
            byte_d  = '0;
            dibit_d = '0;
        end else begin
            dibit_d = dibit_q + 2'd1;
            if (dibit_q == 2'd3) begin
                byte_d = byte_q + BYTE_W'(1);
            end
        end
    end

    assign axiir = (dibit_q == 2'd3) &&
                   ((state_q == ST_HEADER  && byte_q == BYTE_W'(HEADER_BYTES - 1)) ||
                    (state_q == ST_PAYLOAD && byte_q != BYTE_W'(PAYLOAD_BYTES - 1)));

    assign data_d = axiir ? (axiiv ? axiid : 8'h00) : data_q;
    assign fcs    = ~crc;

    // Byte whose dibit goes on the wire next cycle.
    always_comb begin
        next_byte = 8'h00;
        hdr_idx   = 4'(HEADER_BYTES - 1) - byte_d[3:0];
        unique case (state_d)
            ST_PREAMBLE: next_byte = PREAMBLE_BYTE;
            ST_SFD:      next_byte = SFD_BYTE;
            ST_HEADER:   next_byte = HDR[{hdr_idx, 3'b000} +: 8];
            ST_PAYLOAD:  next_byte = data_d;
            ST_FCS:      next_byte = fcs[{byte_d[1:0], 3'b000} +: 8];
            default:     next_byte = 8'h00;
        endcase
    end

    always_comb begin
        txen_d     = (state_d != ST_IDLE) && (state_d != ST_IFG);
        busy_d     = (state_d != ST_IDLE);
        underrun_d = axiir && !axiiv;
        txd_d      = txen_d ? next_byte[{dibit_d, 1'b0} +: 2] : 2'b00;
        crc_init_c = (state_q == ST_PREAMBLE);
        crc_en_c   = (state_d == ST_HEADER) || (state_d == ST_PAYLOAD);
    end

    crc32_dibit u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init_c),
        .en    (crc_en_c),
        .din   (txd_d),
        .crc   (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            byte_q   <= '0;
            dibit_q  <= '0;
            data_q   <= '0;
            txen     <= 1'b0;
            txd      <= 2'b00;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            dibit_q  <= dibit_d;
            data_q   <= data_d;
            txen     <= txen_d;
            txd      <= txd_d;
            busy     <= busy_d;
            underrun <= underrun_d;
        end
    end

endmodule

// File: tb/tb_ether_tx.sv
// Randomized frame-level bench for ether_tx against a byte-level Ethernet frame model.
module tb_ether_tx;

    localparam int unsigned NPAY = 46;
    localparam logic [47:0] DST  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC  = 48'h42_42_42_42_42_42;
    localparam logic [15:0] ETYP = 16'h0800;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        axiiv;
    logic [7:0]  axiid;
    logic        axiir;
    logic        txen;
    logic [1:0]  txd;
    logic        busy;
    logic        underrun;

    logic        c_init, c_en;
    logic [1:0]  c_din;
    logic [31:0] c_crc;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    ether_tx #(
        .DST_MAC       (DST),
        .SRC_MAC       (SRC),
        .ETHERTYPE     (ETYP),
        .PAYLOAD_BYTES (NPAY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axiiv    (axiiv),
        .axiid    (axiid),
        .axiir    (axiir),
        .txen     (txen),
        .txd      (txd),
        .busy     (busy),
        .underrun (underrun)
    );

    crc32_dibit u_crc_ut (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (c_init),
        .en    (c_en),
        .din   (c_din),
        .crc   (c_crc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-at-a-time reflected CRC-32 over a byte list, returns the FCS value.
    function automatic logic [31:0] sw_fcs(input bq_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Drive one frame from the source and compare the wire against the model frame.
    task automatic run_frame(input int drop_idx, input bit incr, input bit b2b);
        bq_t src, exp_pl, hdr, crc_in, exp_frame, got_frame;
        logic [1:0] dq[$];
        logic [31:0] fcs;
        int pre_low = 0, busy_low = 0, hs = 0, ns = 0, first_hs = -1;
        int ur = 0, bad_txd = 0, bad_busy = 0, cyc = 0;
        bit started = 0, done = 0;

        for (int i = 0; i <= NPAY; i++) src.push_back(incr ? 8'(i) : 8'($urandom));
        for (int i = 0; i < NPAY; i++) begin
            if (i == drop_idx)                   exp_pl.push_back(8'h00);
            else if (drop_idx >= 0 && i > drop_idx) exp_pl.push_back(src[i-1]);
            else                                 exp_pl.push_back(src[i]);
        end

        axiiv = 1'b1;
        axiid = src[0];
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (!txen && txd != 2'b00) bad_txd++;
            if (underrun) ur++;
            if (txen) begin
                started = 1;
                dq.push_back(txd);
                if (!busy) bad_busy++;
            end else if (!started) begin
                pre_low++;
                if (!busy) busy_low++;
            end else begin
                done = 1;
            end
            axiiv = 1'b1;
            axiid = src[ns];
            if (axiir) begin
                if (hs == 0) first_hs = dq.size();
                if (hs == drop_idx) axiiv = 1'b0;
                else ns++;
                hs++;
            end
        end
        if (!done) chk("frame_timeout", 32'(cyc), 32'(0));

        chk("txen_len",     32'(dq.size()), 32'(4 * (8 + 14 + NPAY + 4)));
        chk("handshakes",   32'(hs),        32'(NPAY));
        chk("first_accept", 32'(first_hs),  32'(88));
        chk("underrun_cnt", 32'(ur),        32'((drop_idx >= 0) ? 1 : 0));
        chk("txd_when_idle", 32'(bad_txd),  32'(0));
        chk("busy_in_frame", 32'(bad_busy), 32'(0));
        if (b2b) begin
            chk("ifg_gap",       32'(pre_low + 1), 32'(49));
            chk("idle_busy_low", 32'(busy_low),    32'(1));
        end

        for (int i = 0; i < 6; i++) hdr.push_back(DST[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) hdr.push_back(SRC[47 - 8*i -: 8]);
        hdr.push_back(ETYP[15:8]);
        hdr.push_back(ETYP[7:0]);
        crc_in = {hdr, exp_pl};
        fcs = sw_fcs(crc_in);

        for (int i = 0; i < 7; i++) exp_frame.push_back(8'h55);
        exp_frame.push_back(8'hD5);
        exp_frame = {exp_frame, crc_in};
        for (int i = 0; i < 4; i++) exp_frame.push_back(fcs[8*i +: 8]);

        for (int i = 0; i + 3 < dq.size(); i += 4)
            got_frame.push_back({dq[i+3], dq[i+2], dq[i+1], dq[i]});

        for (int i = 0; i < exp_frame.size() && i < got_frame.size(); i++) begin
            if (i < 8)              chk($sformatf("preamble[%0d]", i), 32'(got_frame[i]), 32'(exp_frame[i]));
            else if (i < 22)        chk($sformatf("header[%0d]", i - 8), 32'(got_frame[i]), 32'(exp_frame[i]));
            else if (i < 22 + NPAY) chk($sformatf("payload[%0d]", i - 22), 32'(got_frame[i]), 32'(exp_frame[i]));
            else                    chk($sformatf("fcs[%0d]", i - 22 - NPAY), 32'(got_frame[i]), 32'(exp_frame[i]));
        end
    endtask

    // Start a frame and pull reset while payload byte 20 is being requested.
    task automatic reset_mid_frame();
        int hs = 0, cyc = 0;
        bit hit = 0;
        axiiv = 1'b1;
        while (!hit && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            axiid = 8'($urandom);
            if (axiir) begin
                if (hs == 20) hit = 1;
                hs++;
            end
        end
        if (!hit) chk("reset_timeout", 32'(cyc), 32'(0));
        rst_n = 1'b0;
        #1;
        chk("rst_txen",  32'(txen),  32'(0));
        chk("rst_txd",   32'(txd),   32'(0));
        chk("rst_axiir", 32'(axiir), 32'(0));
        chk("rst_busy",  32'(busy),  32'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_txen", 32'(txen), 32'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        bq_t ascii;
        rst_n  = 1'b0;
        axiiv  = 1'b0;
        axiid  = 8'h00;
        c_init = 1'b0;
        c_en   = 1'b0;
        c_din  = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset_txen",     32'(txen),     32'(0));
        chk("reset_txd",      32'(txd),      32'(0));
        chk("reset_axiir",    32'(axiir),    32'(0));
        chk("reset_busy",     32'(busy),     32'(0));
        chk("reset_underrun", 32'(underrun), 32'(0));
        rst_n = 1'b1;

        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        @(negedge clk);
        c_init = 1'b1;
        @(negedge clk);
        c_init = 1'b0;
        c_en   = 1'b1;
        foreach (ascii[i]) begin
            for (int d = 0; d < 4; d++) begin
                c_din = ascii[i][2*d +: 2];
                @(negedge clk);
            end
        end
        c_en = 1'b0;
        chk("crc_check_value", ~c_crc, sw_fcs(ascii));
        chk("crc_known_value", ~c_crc, 32'hCBF43926);

        repeat (5) begin
            @(negedge clk);
            chk("idle_quiet", 32'({txen, busy, axiir}), 32'(0));
        end

        run_frame(-1, 1'b1, 1'b0);
        run_frame(-1, 1'b0, 1'b1);
        run_frame(10, 1'b0, 1'b1);
        reset_mid_frame();
        run_frame(-1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) run_frame(int'($urandom_range(0, NPAY - 1)), 1'b0, 1'b1);

        axiiv = 1'b0;
        repeat (60) @(negedge clk);
        chk("final_idle", 32'({txen, busy}), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
